az_processor: RTL and testbench

- Minimal 8-bit multi-cycle processor core: internal program ROM, 8-entry register file, and an 8-bit GPIO output register that drives board LEDs.
- Top-level block of the FPGA design; the board oscillator pair and reset button connect directly to it.
- Each instruction takes 2 cycles: FETCH, then EXEC.

---
 rtl/azp_pkg.sv | 60 ++++++
 rtl/azp_regfile.sv | 32 +++
 rtl/az_processor.sv | 131 +++++++++++++
 tb/tb_az_processor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/azp_pkg.sv
// Shared types and constants for the az_processor core: opcodes, FSM states,
// instruction field positions and a decode helper.
package azp_pkg;

    localparam int DATA_W  = 8;
    localparam int INSTR_W = 16;
    localparam int REG_CNT = 8;
    localparam int REG_AW  = 3;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_ADDI = 4'h7,
        OP_OUT  = 4'h8,
        OP_JMP  = 4'h9,
        OP_BNZ  = 4'hA,
        OP_RSVB = 4'hB,
        OP_HALT = 4'hC,
        OP_MUL  = 4'hD,
        OP_RSVE = 4'hE,
        OP_RSVF = 4'hF
    } opcode_e;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_e;

    typedef struct packed {
        opcode_e             op;
        logic [REG_AW-1:0]   rd;
        logic [REG_AW-1:0]   rs;
        logic [DATA_W-1:0]   imm;
    } instr_t;

    // rs and imm overlap in the encoding, so both are extracted unconditionally.
    function automatic instr_t decodeInstr(input logic [INSTR_W-1:0] ir);
        instr_t d;
        d.op  = opcode_e'(ir[OP_MSB:OP_LSB]);
        d.rd  = ir[RD_MSB:RD_LSB];
        d.rs  = ir[RS_MSB:RS_LSB];
        d.imm = ir[IMM_MSB:IMM_LSB];
        return d;
    endfunction

endpackage

// File: rtl/azp_regfile.sv
// 8x8 register file: two combinational read ports, one synchronous write
// port, asynchronous clear on reset.
module azp_regfile
    import azp_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [REG_AW-1:0]   rdAddr_i,
    input  logic [REG_AW-1:0]   rsAddr_i,
    output logic [DATA_W-1:0]   rdData_o,
    output logic [DATA_W-1:0]   rsData_o,
    input  logic                wrEn_i,
    input  logic [REG_AW-1:0]   wrAddr_i,
    input  logic [DATA_W-1:0]   wrData_i
);

    logic [DATA_W-1:0] regs_q [REG_CNT];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wrEn_i) begin
            regs_q[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = regs_q[rdAddr_i];
    assign rsData_o = regs_q[rsAddr_i];

endmodule

// File: rtl/az_processor.sv
// Minimal 8-bit two-cycle (FETCH/EXEC) processor with internal program ROM
// driving an 8-bit GPIO register. Define AZP_MUL_EN to enable opcode D (MUL).
module az_processor
    import azp_pkg::*;
#(
    parameter int    PC_W     = 8,
    parameter string ROM_FILE = ""
)(
    input  logic              oscp,
    input  logic              oscn,
    input  logic              reset_,
    output logic [DATA_W-1:0] GPIOOut
);

    localparam int ROM_DEPTH = 2 ** PC_W;

    typedef logic [ROM_DEPTH-1:0][INSTR_W-1:0] romImg_t;

    // Empty ROM_FILE selects the built-in counter program; unlisted words are NOP.
    function automatic romImg_t romInit();
        romImg_t img;
        img = '0;
        if (ROM_FILE == "") begin
            img[0] = {OP_LDI, 3'd0, 1'b0, 8'h00};
            img[1] = {OP_LDI, 3'd1, 1'b0, 8'h01};
            img[2] = {OP_OUT, 3'd0, 9'd0};
            img[3] = {OP_ADD, 3'd0, 3'd1, 6'd0};
            img[4] = {OP_JMP, 3'd0, 1'b0, 8'h02};
        end
        return img;
    endfunction

    romImg_t romMem = romInit();

    logic unusedOscn;
    assign unusedOscn = oscn;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  gpio_q, gpio_d;
    logic               halted_q, halted_d;

    instr_t             instr;
    logic [DATA_W-1:0]  rdData, rsData;
    logic [DATA_W-1:0]  aluResult;
    logic               aluWrite;
    logic               regWrEn;

    assign instr = decodeInstr(ir_q);

    azp_regfile u_regfile (
        .clk_i    (oscp),
        .rst_i    (reset_),
        .rdAddr_i (instr.rd),
        .rsAddr_i (instr.rs),
        .rdData_o (rdData),
        .rsData_o (rsData),
        .wrEn_i   (regWrEn),
        .wrAddr_i (instr.rd),
        .wrData_i (aluResult)
    );

    always_comb begin
        aluResult = rdData;
        aluWrite  = 1'b0;
        case (instr.op)
            OP_LDI:  begin aluResult = instr.imm;          aluWrite = 1'b1; end
            OP_ADD:  begin aluResult = rdData + rsData;    aluWrite = 1'b1; end
            OP_SUB:  begin aluResult = rdData - rsData;    aluWrite = 1'b1; end
            OP_AND:  begin aluResult = rdData & rsData;    aluWrite = 1'b1; end
            OP_OR:   begin aluResult = rdData | rsData;    aluWrite = 1'b1; end
            OP_XOR:  begin aluResult = rdData ^ rsData;    aluWrite = 1'b1; end
            OP_ADDI: begin aluResult = rdData + instr.imm; aluWrite = 1'b1; end
`ifdef AZP_MUL_EN
            OP_MUL:  begin aluResult = rdData * rsData;    aluWrite = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Once halted, every architectural register holds until reset.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        gpio_d   = gpio_q;
        halted_d = halted_q;
        regWrEn  = 1'b0;
        if (!halted_q) begin
            case (state_q)
                FETCH: begin
                    ir_d    = romMem[pc_q];
                    state_d = EXEC;
                end
                EXEC: begin
                    state_d = FETCH;
                    pc_d    = pc_q + PC_W'(1);
                    regWrEn = aluWrite;
                    case (instr.op)
                        OP_OUT:  gpio_d = rdData;
                        OP_JMP:  pc_d = PC_W'(instr.imm);
                        OP_BNZ:  if (rdData != '0) pc_d = PC_W'(instr.imm);
                        OP_HALT: halted_d = 1'b1;
                        default: ;
                    endcase
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge oscp or posedge reset_) begin
        if (reset_) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            gpio_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            gpio_q   <= gpio_d;
            halted_q <= halted_d;
        end
    end

    assign GPIOOut = gpio_q;

endmodule

// File: tb/tb_az_processor.sv
// Self-checking bench for az_processor: directed programs plus random ROM
// images, compared against an instruction-level model of the ISA.
`timescale 1ns/1ps
module tb_az_processor;

    logic       oscp;
    logic       oscn;
    logic       reset_;
    logic [7:0] GPIOOut;

    int errorCount = 0;
    int checkCount = 0;
    int edgeNum    = 0;

    logic [15:0] mRom [256];
    logic [7:0]  mReg [8];
    logic [7:0]  mPc;
    logic [7:0]  mGpio;
    logic        mHalted;

    az_processor #(.PC_W(8), .ROM_FILE("")) dut (
        .oscp    (oscp),
        .oscn    (oscn),
        .reset_  (reset_),
        .GPIOOut (GPIOOut)
    );

    initial begin
        oscp = 1'b0;
        forever #5 oscp = ~oscp;
    end
    assign oscn = ~oscp;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] instrI(input logic [3:0] op, input logic [2:0] rd,
                                           input logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction

    function automatic logic [15:0] instrR(input logic [3:0] op, input logic [2:0] rd,
                                           input logic [2:0] rs);
        return {op, rd, rs, 6'd0};
    endfunction

    task automatic clearRom();
        for (int i = 0; i < 256; i++) mRom[i] = 16'h0000;
    endtask

    task automatic defaultProgram();
        clearRom();
        mRom[0] = instrI(4'h1, 3'd0, 8'h00);
        mRom[1] = instrI(4'h1, 3'd1, 8'h01);
        mRom[2] = instrR(4'h8, 3'd0, 3'd0);
        mRom[3] = instrR(4'h2, 3'd0, 3'd1);
        mRom[4] = instrI(4'h9, 3'd0, 8'h02);
    endtask

    task automatic randomProgram();
        logic [3:0] op;
        for (int i = 0; i < 256; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hC && $urandom_range(0, 7) != 0) op = 4'h8;
            mRom[i] = {op, 12'($urandom)};
        end
    endtask

    // Instruction-set model: one call executes one whole instruction.
    task automatic modelStep();
        logic [15:0] w;
        int op, rd, rs, imm, a, b;
        if (mHalted) return;
        w   = mRom[mPc];
        op  = int'(w[15:12]);
        rd  = int'(w[11:9]);
        rs  = int'(w[8:6]);
        imm = int'(w[7:0]);
        a   = int'(mReg[rd]);
        b   = int'(mReg[rs]);
        mPc = 8'((int'(mPc) + 1) % 256);
        case (op)
            1:  mReg[rd] = 8'(imm);
            2:  mReg[rd] = 8'((a + b) % 256);
            3:  mReg[rd] = 8'((a - b + 256) % 256);
            4:  mReg[rd] = 8'(a & b);
            5:  mReg[rd] = 8'(a | b);
            6:  mReg[rd] = 8'(a ^ b);
            7:  mReg[rd] = 8'((a + imm) % 256);
            8:  mGpio    = 8'(a);
            9:  mPc      = 8'(imm);
            10: if (a != 0) mPc = 8'(imm);
            12: mHalted  = 1'b1;
`ifdef AZP_MUL_EN
            13: mReg[rd] = 8'((a * b) % 256);
`endif
            default: ;
        endcase
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mReg[i] = 8'h00;
        mPc     = 8'h00;
        mGpio   = 8'h00;
        mHalted = 1'b0;
    endtask

    task automatic loadRom();
        for (int i = 0; i < 256; i++) dut.romMem[i] = mRom[i];
    endtask

    task automatic resetDut(input int holdCycles, input bit doLoad);
        reset_ = 1'b1;
        if (doLoad) loadRom();
        repeat (holdCycles) @(negedge oscp);
        checkOutput("reset gpio", 16'(GPIOOut), 16'h00);
        checkOutput("reset pc", 16'(dut.pc_q), 16'h00);
        modelReset();
        reset_  = 1'b0;
        edgeNum = 0;
    endtask

    // Advance edges; after every EXEC edge compare GPIOOut with the model.
    task automatic applyStimulus(input int nEdges);
        repeat (nEdges) begin
            @(posedge oscp);
            edgeNum++;
            @(negedge oscp);
            if (edgeNum % 2 == 0) begin
                modelStep();
                checkOutput($sformatf("gpio@e%0d", edgeNum), 16'(GPIOOut), 16'(mGpio));
            end
        end
    endtask

    initial begin
        reset_ = 1'b1;

        defaultProgram();
        resetDut(20, 1'b0);
        applyStimulus(1);
        checkOutput("pc after e1", 16'(dut.pc_q), 16'h00);
        applyStimulus(1);
        checkOutput("pc after e2", 16'(dut.pc_q), 16'h01);
        applyStimulus(4);
        checkOutput("default e6", 16'(GPIOOut), 16'h00);
        applyStimulus(6);
        checkOutput("default e12", 16'(GPIOOut), 16'h01);
        applyStimulus(6);
        checkOutput("default e18", 16'(GPIOOut), 16'h02);
        applyStimulus(18);
        checkOutput("default e36", 16'(GPIOOut), 16'h05);
        applyStimulus(1500);
        checkOutput("default e1536", 16'(GPIOOut), 16'hFF);
        applyStimulus(6);
        checkOutput("default wrap e1542", 16'(GPIOOut), 16'h00);

        resetDut(3, 1'b1);
        applyStimulus(48);
        checkOutput("pre-async e48", 16'(GPIOOut), 16'h07);
        #2;
        reset_ = 1'b1;
        #1;
        checkOutput("async gpio", 16'(GPIOOut), 16'h00);
        checkOutput("async pc", 16'(dut.pc_q), 16'h00);
        resetDut(2, 1'b0);
        applyStimulus(12);
        checkOutput("restart e12", 16'(GPIOOut), 16'h01);

        clearRom();
        mRom[0]  = instrI(4'h1, 3'd2, 8'h0F);
        mRom[1]  = instrI(4'h1, 3'd3, 8'h3C);
        mRom[2]  = instrR(4'h4, 3'd2, 3'd3);
        mRom[3]  = instrR(4'h8, 3'd2, 3'd0);
        mRom[4]  = instrR(4'h6, 3'd2, 3'd3);
        mRom[5]  = instrR(4'h8, 3'd2, 3'd0);
        mRom[6]  = instrI(4'h1, 3'd0, 8'h01);
        mRom[7]  = instrI(4'h1, 3'd1, 8'h02);
        mRom[8]  = instrR(4'h3, 3'd0, 3'd1);
        mRom[9]  = instrR(4'h8, 3'd0, 3'd0);
        mRom[10] = instrR(4'hC, 3'd0, 3'd0);
        resetDut(3, 1'b1);
        applyStimulus(8);
        checkOutput("alu and", 16'(GPIOOut), 16'h0C);
        applyStimulus(4);
        checkOutput("alu xor", 16'(GPIOOut), 16'h30);
        applyStimulus(8);
        checkOutput("alu sub wrap", 16'(GPIOOut), 16'hFF);
        applyStimulus(4);

        clearRom();
        mRom[0] = instrI(4'h1, 3'd0, 8'h03);
        mRom[1] = instrI(4'h7, 3'd0, 8'hFF);
        mRom[2] = instrI(4'hA, 3'd0, 8'h01);
        mRom[3] = instrI(4'h1, 3'd4, 8'hA5);
        mRom[4] = instrR(4'h8, 3'd4, 3'd0);
        mRom[5] = instrR(4'hC, 3'd0, 3'd0);
        resetDut(3, 1'b1);
        applyStimulus(16);
        checkOutput("branch e16", 16'(GPIOOut), 16'h00);
        applyStimulus(2);
        checkOutput("branch e18", 16'(GPIOOut), 16'hA5);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(10);
            checkOutput("halt gpio", 16'(GPIOOut), 16'hA5);
            checkOutput("halt pc", 16'(dut.pc_q), 16'h06);
        end

        clearRom();
        mRom[0] = instrI(4'h1, 3'd0, 8'h13);
        mRom[1] = instrI(4'h1, 3'd1, 8'h11);
        mRom[2] = instrR(4'hD, 3'd0, 3'd1);
        mRom[3] = instrR(4'h8, 3'd0, 3'd0);
        mRom[4] = instrR(4'hC, 3'd0, 3'd0);
        resetDut(3, 1'b1);
        applyStimulus(8);
`ifdef AZP_MUL_EN
        checkOutput("mul", 16'(GPIOOut), 16'h43);
`else
        checkOutput("mul as nop", 16'(GPIOOut), 16'h13);
`endif

        for (int r = 0; r < 4; r++) begin
            randomProgram();
            resetDut(3, 1'b1);
            applyStimulus(300);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
